// File: rtl/jk_excite_drv.sv
// Excitation driver for an external JK flip-flop: queues target bits, drives J/K
// for one cycle per bit, then checks the fed-back Q and tracks mismatches.
module jk_excite_drv #(
    parameter int DEPTH   = 4,
    parameter int DC_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tgt_valid,
    input  logic        tgt_bit,
    output logic        tgt_ready,
    output logic        j,
    output logic        k,
    input  logic        q_fb,
    input  logic        clr_err,
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [15:0] bit_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic DC = (DC_MODE != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            q_model_q, q_model_d;
    logic            exp_q, exp_d;
    logic            j_q, j_d;
    logic            k_q, k_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [15:0]     bit_cnt_q, bit_cnt_d;

    logic full;
    logic push;
    logic pop;
    logic head;
    logic mismatch;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        q_model_d = q_model_q;
        exp_d     = exp_q;
        j_d       = 1'b0;
        k_d       = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;
        mismatch  = 1'b0;

        // A full FIFO refuses the offer even if the FSM frees a slot this cycle.
        full = (count_q == FULL_CNT);
        push = tgt_valid && !full;
        pop  = (state_q == IDLE) && (count_q != '0);
        head = mem_q[rd_ptr_q];

        if (push) begin
            mem_d[wr_ptr_q] = tgt_bit;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    j_d     = q_model_q ? DC : head;
                    k_d     = q_model_q ? !head : DC;
                    exp_d   = head;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                mismatch  = (q_fb != exp_q);
                q_model_d = q_fb;
                bit_cnt_d = bit_cnt_q + 16'd1;
                state_d   = IDLE;
                if (mismatch) begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clearing wins over a mismatch found in the same cycle.
        if (clr_err) begin
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            q_model_q <= 1'b0;
            exp_q     <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            bit_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            q_model_q <= q_model_d;
            exp_q     <= exp_d;
            j_q       <= j_d;
            k_q       <= k_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign tgt_ready = !full;
    assign j         = j_q;
    assign k         = k_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_jk_excite_drv.sv
// Bench for jk_excite_drv: two instances (fill 0 and fill 1) each driving a golden
// JK flip-flop, with a queued reference of J/K pulses, Q results and error counts.
module tb_jk_excite_drv;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tgt_valid = 1'b0;
    logic tgt_bit = 1'b0;
    logic clr_err = 1'b0;
    logic stuck = 1'b0;

    logic rdy0, j0, k0, busy0, err0, rdy1, j1, k1, busy1, err1;
    logic [7:0]  ec0, ec1;
    logic [15:0] bc0, bc1;
    logic gq0 = 1'b0;
    logic gq1 = 1'b0;
    logic qfb0, qfb1;

    int n_chk = 0;
    int n_pass = 0;

    // expected entry: {mismatch, q after bit, j, k}
    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic qm = 1'b0;

    always #5 clk = ~clk;

    assign qfb0 = stuck ? 1'b0 : gq0;
    assign qfb1 = stuck ? 1'b0 : gq1;

    jk_excite_drv #(.DEPTH(4), .DC_MODE(0)) u0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(rdy0), .j(j0), .k(k0), .q_fb(qfb0), .clr_err(clr_err),
        .busy(busy0), .err(err0), .err_cnt(ec0), .bit_cnt(bc0)
    );

    jk_excite_drv #(.DEPTH(4), .DC_MODE(1)) u1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(rdy1), .j(j1), .k(k1), .q_fb(qfb1), .clr_err(clr_err),
        .busy(busy1), .err(err1), .err_cnt(ec1), .bit_cnt(bc1)
    );

    // Golden JK flip-flops sharing the driver's reset.
    always @(posedge clk) begin
        if (rst) begin
            gq0 <= 1'b0;
            gq1 <= 1'b0;
        end else begin
            case ({j0, k0})
                2'b01: gq0 <= 1'b0;
                2'b10: gq0 <= 1'b1;
                2'b11: gq0 <= ~gq0;
                default: gq0 <= gq0;
            endcase
            case ({j1, k1})
                2'b01: gq1 <= 1'b0;
                2'b10: gq1 <= 1'b1;
                2'b11: gq1 <= ~gq1;
                default: gq1 <= gq1;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: excitation table applied to the Q the driver last observed.
    task automatic model_push(input logic b);
        logic [1:0] jk_f0, jk_f1;
        logic q_after;
        jk_f0   = qm ? {1'b0, ~b} : {b, 1'b0};
        jk_f1   = qm ? {1'b1, ~b} : {b, 1'b1};
        q_after = stuck ? 1'b0 : b;
        exp_q0.push_back({q_after != b, q_after, jk_f0});
        exp_q1.push_back({q_after != b, q_after, jk_f1});
        qm = q_after;
    endtask

    // Offers one bit; leaves tgt_valid high so back-to-back calls stream.
    task automatic push_bit(input logic b, output int waits);
        tgt_valid = 1'b1;
        tgt_bit   = b;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (rdy0) begin
                model_push(b);
                cyc();
                break;
            end
            waits++;
            cyc();
            if (waits > 50) begin
                chk("push_timeout", 32'(waits), 32'd0);
                break;
            end
        end
    endtask

    task automatic do_reset(input int n);
        tgt_valid = 1'b0;
        clr_err   = 1'b0;
        rst       = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
        qm  = 1'b0;
        cyc();
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        cyc();
        chk("busy_idle0", 32'(busy0), 32'd0);
        chk("busy_idle1", 32'(busy1), 32'd0);
    endtask

    // Monitor: a change of bit_cnt marks a completed bit; the DRIVE cycle is two
    // samples back and the CHECK cycle one sample back.
    logic       rst_h1 = 1'b1;
    logic       clr_h1 = 1'b0;
    logic [1:0] jk_h1 [2];
    logic [1:0] jk_h2 [2];
    logic       q_h1  [2];
    logic [15:0] bc_prev [2];
    logic [15:0] bm      [2];
    int          mis_m   [2];

    initial begin
        logic [3:0] e;
        logic [1:0] jk_now;
        logic [15:0] bc_now;
        logic [7:0] ec_now;
        logic err_now, busy_now, rdy_now, qfb_now;
        for (int i = 0; i < 2; i++) begin
            jk_h1[i] = 2'b00; jk_h2[i] = 2'b00; q_h1[i] = 1'b0;
            bc_prev[i] = 16'd0; bm[i] = 16'd0; mis_m[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                jk_now   = (i == 0) ? {j0, k0} : {j1, k1};
                bc_now   = (i == 0) ? bc0 : bc1;
                ec_now   = (i == 0) ? ec0 : ec1;
                err_now  = (i == 0) ? err0 : err1;
                busy_now = (i == 0) ? busy0 : busy1;
                rdy_now  = (i == 0) ? rdy0 : rdy1;
                qfb_now  = (i == 0) ? qfb0 : qfb1;
                if (rst_h1) begin
                    chk("rst_jk", 32'(jk_now), 32'd0);
                    chk("rst_busy", 32'(busy_now), 32'd0);
                    chk("rst_err", 32'(err_now), 32'd0);
                    chk("rst_err_cnt", 32'(ec_now), 32'd0);
                    chk("rst_bit_cnt", 32'(bc_now), 32'd0);
                    chk("rst_ready", 32'(rdy_now), 32'd1);
                    if (i == 0) exp_q0.delete(); else exp_q1.delete();
                    bc_prev[i] = 16'd0; bm[i] = 16'd0; mis_m[i] = 0;
                end else if (bc_now != bc_prev[i]) begin
                    if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk("spurious_bit", 32'(bc_now), 32'(bc_prev[i]));
                    end else begin
                        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        bm[i] = bm[i] + 16'd1;
                        chk("drive_jk", 32'(jk_h2[i]), 32'(e[1:0]));
                        chk("check_jk_zero", 32'(jk_h1[i]), 32'd0);
                        chk("q_fb", 32'(q_h1[i]), 32'(e[2]));
                        chk("bit_cnt", 32'(bc_now), 32'(bm[i]));
                        if (clr_h1) mis_m[i] = 0;
                        else if (e[3] && mis_m[i] < 255) mis_m[i]++;
                        chk("err_cnt", 32'(ec_now), 32'(mis_m[i]));
                        chk("err", 32'(err_now), 32'(mis_m[i] != 0));
                    end
                    bc_prev[i] = bc_now;
                end else if (clr_h1) begin
                    mis_m[i] = 0;
                    chk("clr_err_cnt", 32'(ec_now), 32'd0);
                end
                jk_h2[i] = jk_h1[i];
                jk_h1[i] = jk_now;
                q_h1[i]  = qfb_now;
            end
            rst_h1 = rst;
            clr_h1 = clr_err;
        end
    end

    initial begin
        int w;
        logic [4:0] seq;
        do_reset(3);

        // Fixed sequence 1,1,0,0,1 on both fill modes.
        seq = 5'b10011;
        for (int n = 0; n < 5; n++) push_bit(seq[n], w);
        tgt_valid = 1'b0;
        drain(100);
        chk("seq_bit_cnt", 32'(bc0), 32'd5);
        chk("seq_err", 32'(err1), 32'd0);

        // Streaming 7 bits from empty: FIFO fills, 7th waits two cycles.
        for (int n = 0; n < 7; n++) begin
            push_bit(1'($urandom_range(0, 1)), w);
            chk("ready_wait", 32'(w), (n == 6) ? 32'd2 : 32'd0);
        end
        tgt_valid = 1'b0;
        drain(100);

        // Random bits, random gaps, occasional clears.
        for (int n = 0; n < 150; n++) begin
            push_bit(1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 2) == 0) begin
                tgt_valid = 1'b0;
                repeat ($urandom_range(1, 4)) cyc();
            end
            if ($urandom_range(0, 15) == 0) begin
                tgt_valid = 1'b0;
                clr_err = 1'b1;
                cyc();
                clr_err = 1'b0;
            end
        end
        tgt_valid = 1'b0;
        drain(800);

        // q_fb stuck at 0 with 300 ones: error saturation.
        do_reset(2);
        stuck = 1'b1;
        for (int n = 0; n < 300; n++) push_bit(1'b1, w);
        tgt_valid = 1'b0;
        drain(1200);
        chk("sat_err", 32'(err0), 32'd1);
        chk("sat_err_cnt", 32'(ec1), 32'd255);
        chk("sat_bit_cnt", 32'(bc0), 32'd300);

        // Mismatch vs clear in the same CHECK cycle.
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        push_bit(1'b1, w);
        tgt_valid = 1'b0;
        drain(50);
        chk("one_mismatch", 32'(ec0), 32'd1);
        push_bit(1'b1, w);
        tgt_valid = 1'b0;
        cyc();
        chk("busy_drive", 32'(busy0), 32'd1);
        cyc();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        drain(50);
        chk("clr_same_err", 32'(err0), 32'd0);
        chk("clr_same_cnt", 32'(ec1), 32'd0);
        stuck = 1'b0;
        do_reset(2);

        // Reset while DRIVE with three bits queued.
        for (int n = 0; n < 5; n++) push_bit(1'($urandom_range(0, 1)), w);
        tgt_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        qm  = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("post_rst_jk", 32'({j0, k0, j1, k1}), 32'd0);
            chk("post_rst_busy", 32'(busy0 | busy1), 32'd0);
            chk("post_rst_bit_cnt", 32'(bc0), 32'd0);
            cyc();
        end
        chk("final_queue", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jk_excite_drv.md
JK_EXCITE_DRV -- requirements
Module: jk_excite_drv

Interface
REQ-001 Parameter DEPTH, default 4, meaning target-bit FIFO depth (power of two, 2..16).
REQ-002 Parameter DC_MODE, default 0, meaning don't-care fill for J/K (0 = fill 0, 1 = fill 1).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 tgt_valid  input  1  target bit offered.
REQ-006 tgt_bit  input  1  desired next Q of the driven JK flip-flop.
REQ-007 tgt_ready  output  1  FIFO can accept; equals !full, combinational from count.
REQ-008 j  output  1  registered J drive to the external JK flip-flop.
REQ-009 k  output  1  registered K drive to the external JK flip-flop.
REQ-010 q_fb  input  1  Q fed back from the external JK flip-flop.
REQ-011 clr_err  input  1  synchronous clear of err and err_cnt.
REQ-012 busy  output  1  high when FSM is not IDLE or FIFO is non-empty.
REQ-013 err  output  1  sticky mismatch flag.
REQ-014 err_cnt  output  8  mismatch count, saturating at 255.
REQ-015 bit_cnt  output  16  count of completed bits, wraps 65535 -> 0.

Function
REQ-016 Push SHALL occur when tgt_valid && tgt_ready; data is held FIFO-ordered; a push offered while full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-017 FSM states SHALL be IDLE, DRIVE, CHECK.
REQ-018 IDLE: if FIFO non-empty, pop head as tgt, register j/k from excitation of (q_model -> tgt), register exp <= tgt, go DRIVE; else stay IDLE.
REQ-019 Excitation: 0->0 gives J=0,K=X; 0->1 gives J=1,K=X; 1->0 gives J=X,K=1; 1->1 gives J=X,K=0; X SHALL equal DC_MODE.
REQ-020 DRIVE: lasts exactly one cycle with j/k stable; on exit, j and k SHALL be registered to 0/0; go CHECK.
REQ-021 In IDLE and CHECK, j=k=0 so the external flip-flop holds.
REQ-022 CHECK: compare q_fb with exp; on mismatch, set err, increment err_cnt (saturate at 255); in all cases q_model <= q_fb, bit_cnt increments, go IDLE.
REQ-023 Latency SHALL be: pop at edge n, j/k valid cycle n+1, comparison cycle n+2; throughput one bit per 3 cycles.
REQ-024 clr_err SHALL have priority: err <= 0 and err_cnt <= 0; a mismatch detected in the same cycle SHALL be discarded; q_model and bit_cnt update normally.
REQ-025 err SHALL remain 1 until rst or clr_err.
REQ-026 tgt_valid while empty and IDLE SHALL NOT bypass the FIFO; the pop occurs no earlier than the following cycle.

Reset
REQ-027 On rst: state=IDLE, FIFO empty, q_model=0, exp=0, j=0, k=0, err=0, err_cnt=0, bit_cnt=0; tgt_ready=1 in the cycle after rst deasserts.
REQ-028 rst mid-operation (any state) SHALL abort the in-flight bit, discard FIFO contents, and not count the bit; the external flip-flop shares rst and also resets Q to 0.
REQ-029 rst SHALL have priority over push, pop and clr_err.

Verification
REQ-030 DC_MODE=0, push 1,1,0,0,1 with the driver connected to a golden JK flip-flop: j/k pulses are 10,00,01,00,10; q_fb follows 1,1,0,0,1; err=0; bit_cnt=5.
REQ-031 DC_MODE=1, same sequence: j/k pulses are 11,10,11,01,11; q_fb follows 1,1,0,0,1; err=0.
REQ-032 Hold tgt_valid=1 with 6 bits and no pops possible: tgt_ready=0 after 4 accepted (DEPTH=4); the 5th and 6th bits are accepted only as pops free slots; order is preserved.
REQ-033 Force q_fb stuck at 0, push 1 x 300: err=1 after the first CHECK; err_cnt saturates at 255; bit_cnt=300.
REQ-034 Mismatch and clr_err asserted in the same CHECK cycle: err=0 and err_cnt=0 afterwards.
REQ-035 Assert rst during DRIVE with 3 bits queued: next cycle j=k=0, busy=0, bit_cnt=0, and no further pulses are issued.
